// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: direction-counter encodings,
// reset/allocation counter values and PC index/tag extraction helpers.
package bp_pkg;

    // 2-bit direction counter: strongly/weakly not-taken, weakly/strongly taken
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;
    localparam ctr_e CTR_ALLOC = WT;

    // Helpers work on a zero-extended 64-bit PC so any XLEN up to 64 fits
    localparam int unsigned PC_MAX_W = 64;

    // Table index: word-aligned PC bits just above the byte offset
    function automatic logic [PC_MAX_W-1:0] idx_of(input logic [PC_MAX_W-1:0] pc,
                                                    input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Tag: the PC bits immediately above the index field
    function automatic logic [PC_MAX_W-1:0] tag_of(input logic [PC_MAX_W-1:0] pc,
                                                    input int unsigned idx_w,
                                                    input int unsigned tag_w);
        return (pc >> (idx_w + 32'd2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state for a 2-bit saturating direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_taken,
    output ctr_e o_ctr_next
);

    // Step toward taken/not-taken, holding at the ST/SNT extremes
    always_comb begin
        o_ctr_next = i_ctr;
        if (i_taken) begin
            if (i_ctr != ST) begin
                o_ctr_next = ctr_e'(i_ctr + 2'd1);
            end else begin
                o_ctr_next = ST;
            end
        end else begin
            if (i_ctr != SNT) begin
                o_ctr_next = ctr_e'(i_ctr - 2'd1);
            end else begin
                o_ctr_next = SNT;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters for the fetch stage.
// Lookup is combinational on lookup_pc; update is synchronous from execute.
// Optional gshare direction indexing is enabled with the macro
// BRANCH_PREDICTOR_GSHARE_EN (separate hashed counter array plus a GHR).
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_mispredict,
    output logic [CNT_W-1:0] stat_updates,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        ctr_e             ctr;
    } entry_t;

    entry_t           r_table [ENTRIES];
    logic [CNT_W-1:0] r_stat_upd;
    logic [CNT_W-1:0] r_stat_mis;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    entry_t           w_lk_entry;
    logic             w_lk_hit;
    ctr_e             w_lk_ctr;
    logic             w_lk_taken;

    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    entry_t           w_up_entry;
    logic             w_up_hit;
    ctr_e             w_up_ctr_next;

    assign w_lk_idx   = IDX_W'(idx_of(PC_MAX_W'(lookup_pc), IDX_W));
    assign w_lk_tag   = TAG_W'(tag_of(PC_MAX_W'(lookup_pc), IDX_W, TAG_W));
    assign w_lk_entry = r_table[w_lk_idx];
    assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

    assign w_up_idx   = IDX_W'(idx_of(PC_MAX_W'(upd_pc), IDX_W));
    assign w_up_tag   = TAG_W'(tag_of(PC_MAX_W'(upd_pc), IDX_W, TAG_W));
    assign w_up_entry = r_table[w_up_idx];
    assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

    // Per-entry counter next-state for the update path
    sat_counter2 u_ctr_upd (
        .i_ctr      (w_up_entry.ctr),
        .i_taken    (upd_taken),
        .o_ctr_next (w_up_ctr_next)
    );

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;
    ctr_e             r_gctr [ENTRIES];
    logic [IDX_W-1:0] w_lk_cidx;
    logic [IDX_W-1:0] w_up_cidx;
    ctr_e             w_gctr_next;

    assign w_lk_cidx = w_lk_idx ^ r_ghr;
    assign w_up_cidx = w_up_idx ^ r_ghr;
    assign w_lk_ctr  = r_gctr[w_lk_cidx];

    // Hashed counter next-state; hit/miss still comes from the unhashed entry
    sat_counter2 u_ctr_gshare (
        .i_ctr      (r_gctr[w_up_cidx]),
        .i_taken    (upd_taken),
        .o_ctr_next (w_gctr_next)
    );

    // Global history and hashed direction counters, trained at resolution
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_gctr[i] <= CTR_RESET;
            end
        end else if (upd_valid) begin
            r_ghr <= {r_ghr[IDX_W-2:0], upd_taken};
            if (w_up_hit) begin
                r_gctr[w_up_cidx] <= w_gctr_next;
            end else if (upd_taken) begin
                r_gctr[w_up_cidx] <= CTR_ALLOC;
            end else begin
                r_gctr[w_up_cidx] <= r_gctr[w_up_cidx];
            end
        end else begin
            r_ghr <= r_ghr;
        end
    end
`else
    assign w_lk_ctr = w_lk_entry.ctr;
`endif

    assign w_lk_taken  = w_lk_hit && w_lk_ctr[1];
    assign pred_hit    = w_lk_hit;
    assign pred_taken  = w_lk_taken;
    assign pred_target = w_lk_taken ? w_lk_entry.target : (lookup_pc + XLEN'(3'd4));

    // BTB entry update: train on hit, allocate on taken miss, ignore not-taken miss
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i].valid  <= 1'b0;
                r_table[i].tag    <= '0;
                r_table[i].target <= '0;
                r_table[i].ctr    <= CTR_RESET;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                r_table[w_up_idx].ctr <= w_up_ctr_next;
                if (upd_taken) begin
                    r_table[w_up_idx].target <= upd_target;
                end
            end else if (upd_taken) begin
                r_table[w_up_idx].valid  <= 1'b1;
                r_table[w_up_idx].tag    <= w_up_tag;
                r_table[w_up_idx].target <= upd_target;
                r_table[w_up_idx].ctr    <= CTR_ALLOC;
            end else begin
                r_table[w_up_idx] <= w_up_entry;
            end
        end
    end

    // Saturating performance counters (no wrap at all-ones)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_upd <= '0;
            r_stat_mis <= '0;
        end else if (upd_valid) begin
            if (r_stat_upd != {CNT_W{1'b1}}) begin
                r_stat_upd <= r_stat_upd + CNT_W'(1'b1);
            end
            if (upd_mispredict && (r_stat_mis != {CNT_W{1'b1}})) begin
                r_stat_mis <= r_stat_mis + CNT_W'(1'b1);
            end
        end
    end

    assign stat_updates     = r_stat_upd;
    assign stat_mispredicts = r_stat_mis;

endmodule
